md_sequencer: RTL

Multi-cycle multiply/divide sequencer owning the HI/LO registers of the pipelined MIPS core. It accepts mult/multu/div/divu launches and mthi/mtlo writes, holds operands for the fixed operation latency, then commits the result to HI/LO. It sits beside the EX stage and exports busy/stall so that hazard logic can freeze any HI/LO-dependent instruction.

---
 rtl/md_sequencer_if.sv | 27 ++
 rtl/md_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/md_sequencer_if.sv
// Handshake/data bundle between the decode/EX stages and the HI/LO sequencer.
interface md_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        load_HI;
  logic        load_LO;
  logic [31:0] load_value;
  logic        md_request;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues launches/loads, observes status and HI/LO.
  modport master (
    output start, op, operand_a, operand_b, load_HI, load_LO, load_value, md_request,
    input  busy, stall, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op, operand_a, operand_b, load_HI, load_LO, load_value, md_request,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO. Operands are latched at launch,
// the result is formed combinationally from the latches and committed when the
// down-counter expires, giving a fixed architectural latency per op class.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset_n,
  md_sequencer_if.slave bus
);

  localparam logic [3:0] MULT_INIT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_INIT  = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [31:0] hi_q, lo_q;

  logic        launch, commit;
  logic [31:0] res_hi, res_lo;

  // Products: signed uses sign-extended 64-bit operands, unsigned zero-extended.
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  assign sprod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign uprod = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide via magnitudes: avoids the -2^31 / -1 overflow case, since the
  // negated 0x80000000 magnitude wraps back to 0x80000000 as required.
  logic [31:0] a_mag, b_mag, sq_mag, sr_mag, uq, ur;
  logic        div_zero;
  assign a_mag    = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign div_zero = (b_q == 32'd0);
  assign sq_mag   = div_zero ? 32'd0 : (a_mag / b_mag);
  assign sr_mag   = div_zero ? 32'd0 : (a_mag % b_mag);
  assign uq       = div_zero ? 32'd0 : (a_q / b_q);
  assign ur       = div_zero ? 32'd0 : (a_q % b_q);

  // Select the result to commit; divide-by-zero leaves HI/LO as they are.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      2'b00: {res_hi, res_lo} = sprod;
      2'b01: {res_hi, res_lo} = uprod;
      2'b10: if (!div_zero) begin
        res_lo = (a_q[31] ^ b_q[31]) ? (~sq_mag + 32'd1) : sq_mag;
        res_hi = a_q[31] ? (~sr_mag + 32'd1) : sr_mag;
      end
      default: if (!div_zero) begin
        res_lo = uq;
        res_hi = ur;
      end
    endcase
  end

  // Next-state: launch from IDLE, return when the counter hits zero.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        launch    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (cnt == 4'd0) begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Operand latches, latency counter and HI/LO; loads only land in an idle,
  // non-launching cycle so a launch always wins over a same-cycle load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 2'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (launch) begin
      a_q  <= bus.operand_a;
      b_q  <= bus.operand_b;
      op_q <= bus.op;
      cnt  <= bus.op[1] ? DIV_INIT : MULT_INIT;
    end else if (state == RUN) begin
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      if (bus.load_HI) hi_q <= bus.load_value;
      if (bus.load_LO) lo_q <= bus.load_value;
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.stall = bus.md_request & (bus.busy | bus.start);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
